// File: rtl/mau_normalizer.sv
// ---------------------------------------------------------------------------
// mau_normalizer
//
// Post-add normalisation stage of the Matrix Acceleration Unit. It sits
// directly after the MAU adder. The adder's raw result is a carry-inclusive
// mantissa, an exponent and a sign. This stage turns it into a normalised
// MAU float: an explicit leading one at bit MANT_W-1, a biased exponent, and
// the sign.
//
// The stage normalises iteratively and shifts left by one bit per cycle.
// A start/busy/done handshake sequences each operation. Exponent overflow
// saturates the result, and exponent underflow flushes the result to zero.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset (0 = in reset)
//   start         request; raw_* is sampled only while idle
//   raw_mantissa  adder mantissa, MANT_W+1 bits, top bit is the carry out
//   raw_exponent  adder exponent, EXP_W bits, unsigned biased
//   raw_sign      adder sign
//   c_mantissa    normalised mantissa (loads on entry to DONE)
//   c_exponent    normalised exponent (loads on entry to DONE)
//   c_sign        result sign (0 for zero and flushed results)
//   busy          high from the sampling edge until DONE is left
//   done          one-cycle pulse, result valid
//   overflow      exponent saturated for the current result
//   underflow     result flushed to zero for the current result
// ---------------------------------------------------------------------------
module mau_normalizer #(
   parameter int MANT_W = 18,
   parameter int EXP_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MANT_W:0]   raw_mantissa,
   input  logic [EXP_W-1:0]  raw_exponent,
   input  logic              raw_sign,
   output logic [MANT_W-1:0] c_mantissa,
   output logic [EXP_W-1:0]  c_exponent,
   output logic              c_sign,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              underflow
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
   localparam logic [EXP_W-1:0]  EXP_ZERO = '0;
   localparam logic [EXP_W-1:0]  EXP_ONE  = EXP_W'(1);
   localparam logic [MANT_W-1:0] MANT_SAT = '1;

   state_t state_q, state_d;

   // Working copy of the operand while it is being normalised.
   logic [MANT_W:0]   work_mant_q, work_mant_d;
   logic [EXP_W-1:0]  work_exp_q,  work_exp_d;
   logic              work_sign_q, work_sign_d;

   // Registered result and flags. They are visible on the ports.
   logic [MANT_W-1:0] c_mant_q, c_mant_d;
   logic [EXP_W-1:0]  c_exp_q,  c_exp_d;
   logic              c_sign_q, c_sign_d;
   logic              ovf_q,    ovf_d;
   logic              unf_q,    unf_d;

   // Decodes of the working operand. CHECK and SHIFT both use them.
   logic mant_is_zero;
   logic carry_set;
   logic lead_set;
   logic exp_is_zero;
   logic exp_is_max;

   always_comb begin
      mant_is_zero = (work_mant_q == '0);
      carry_set    = work_mant_q[MANT_W];
      lead_set     = work_mant_q[MANT_W-1];
      exp_is_zero  = (work_exp_q == EXP_ZERO);
      exp_is_max   = (work_exp_q == EXP_MAX);
   end

   // State register plus all datapath flops. Reset clears everything. A
   // reset during CHECK or SHIFT therefore drops the operation silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         work_mant_q <= '0;
         work_exp_q  <= '0;
         work_sign_q <= 1'b0;
         c_mant_q    <= '0;
         c_exp_q     <= '0;
         c_sign_q    <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_mant_q <= work_mant_d;
         work_exp_q  <= work_exp_d;
         work_sign_q <= work_sign_d;
         c_mant_q    <= c_mant_d;
         c_exp_q     <= c_exp_d;
         c_sign_q    <= c_sign_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // Next-state and datapath logic.
   //
   // The result registers change only on the edge that enters DONE. They
   // therefore hold the previous result through the next operation.
   //
   // Rule order in CHECK matters:
   //   1. A zero mantissa is tested first, so zero never shifts.
   //   2. The carry bit is tested before the leading one.
   //   3. An already-normalised operand is accepted even at exponent 0.
   //
   // SHIFT can never see a carry. A shift happens only with the leading bit
   // clear, so the carry bit stays clear. A non-zero operand reaches the
   // leading position within MANT_W-1 shifts, so no shift counter is needed.
   always_comb begin
      state_d     = state_q;
      work_mant_d = work_mant_q;
      work_exp_d  = work_exp_q;
      work_sign_d = work_sign_q;
      c_mant_d    = c_mant_q;
      c_exp_d     = c_exp_q;
      c_sign_d    = c_sign_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_mant_d = raw_mantissa;
               work_exp_d  = raw_exponent;
               work_sign_d = raw_sign;
               ovf_d       = 1'b0;
               unf_d       = 1'b0;
               state_d     = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (mant_is_zero) begin
               c_mant_d = '0;
               c_exp_d  = EXP_ZERO;
               c_sign_d = 1'b0;
               state_d  = ST_DONE;
            end else if (carry_set && exp_is_max) begin
               c_mant_d = MANT_SAT;
               c_exp_d  = EXP_MAX;
               c_sign_d = work_sign_q;
               ovf_d    = 1'b1;
               state_d  = ST_DONE;
            end else if (carry_set) begin
               // Renormalise the carry: drop the LSB and bump the exponent.
               c_mant_d = work_mant_q[MANT_W:1];
               c_exp_d  = work_exp_q + EXP_ONE;
               c_sign_d = work_sign_q;
               state_d  = ST_DONE;
            end else if (lead_set) begin
               c_mant_d = work_mant_q[MANT_W-1:0];
               c_exp_d  = work_exp_q;
               c_sign_d = work_sign_q;
               state_d  = ST_DONE;
            end else if (exp_is_zero) begin
               c_mant_d = '0;
               c_exp_d  = EXP_ZERO;
               c_sign_d = 1'b0;
               unf_d    = 1'b1;
               state_d  = ST_DONE;
            end else begin
               work_mant_d = {work_mant_q[MANT_W-1:0], 1'b0};
               work_exp_d  = work_exp_q - EXP_ONE;
               state_d     = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (lead_set) begin
               c_mant_d = work_mant_q[MANT_W-1:0];
               c_exp_d  = work_exp_q;
               c_sign_d = work_sign_q;
               state_d  = ST_DONE;
            end else if (exp_is_zero) begin
               c_mant_d = '0;
               c_exp_d  = EXP_ZERO;
               c_sign_d = 1'b0;
               unf_d    = 1'b1;
               state_d  = ST_DONE;
            end else begin
               work_mant_d = {work_mant_q[MANT_W-1:0], 1'b0};
               work_exp_d  = work_exp_q - EXP_ONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs decode directly from the state register.
   always_comb begin
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
   end

   always_comb begin
      c_mantissa = c_mant_q;
      c_exponent = c_exp_q;
      c_sign     = c_sign_q;
      overflow   = ovf_q;
      underflow  = unf_q;
   end

endmodule

// File: tb/tb_mau_normalizer.sv
// ---------------------------------------------------------------------------
// tb_mau_normalizer
//
// Self-checking bench for mau_normalizer.
//
// A table of vectors drives the main function and its boundary cases. Each
// started operation pushes its expected result onto a scoreboard queue. The
// entry is popped when done is seen.
//
// Hand-written sequences cover three corner cases:
//   - start asserted while busy,
//   - a back-to-back start,
//   - an asynchronous reset during SHIFT.
// ---------------------------------------------------------------------------
module tb_mau_normalizer;

   typedef struct {
      logic [18:0] raw_m;
      logic [4:0]  raw_e;
      logic        raw_s;
      logic [17:0] exp_m;
      logic [4:0]  exp_e;
      logic        exp_s;
      logic        exp_ovf;
      logic        exp_unf;
      int          exp_lat;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [18:0] raw_mantissa;
   logic [4:0]  raw_exponent;
   logic        raw_sign;
   logic [17:0] c_mantissa;
   logic [4:0]  c_exponent;
   logic        c_sign;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        underflow;

   int   checks;
   int   errors;
   int   done_count;
   vec_t sb_q[$];
   vec_t vecs[12];

   mau_normalizer #(.MANT_W(18), .EXP_W(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .raw_mantissa (raw_mantissa),
      .raw_exponent (raw_exponent),
      .raw_sign     (raw_sign),
      .c_mantissa   (c_mantissa),
      .c_exponent   (c_exponent),
      .c_sign       (c_sign),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts done pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (done) done_count++;
   end

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Drives one start pulse from a mid-cycle point. On return the time is
   // just after the sampling edge, which counts as edge 1 of the latency.
   task automatic apply_stimulus(input vec_t v, input bit expect_result);
      raw_mantissa = v.raw_m;
      raw_exponent = v.raw_e;
      raw_sign     = v.raw_s;
      start        = 1'b1;
      if (expect_result) sb_q.push_back(v);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Waits a bounded number of edges for done, then compares the result
   // against the oldest scoreboard entry. lat0 is the number of edges
   // already elapsed since the sampling edge.
   task automatic check_output(input int lat0);
      int   lat;
      vec_t e;
      lat = lat0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val("done_seen", 32'(done), 32'd1);
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         check_val("c_mantissa", 32'(c_mantissa), 32'(e.exp_m));
         check_val("c_exponent", 32'(c_exponent), 32'(e.exp_e));
         check_val("c_sign",     32'(c_sign),     32'(e.exp_s));
         check_val("overflow",   32'(overflow),   32'(e.exp_ovf));
         check_val("underflow",  32'(underflow),  32'(e.exp_unf));
         check_val("latency",    32'(lat),        32'(e.exp_lat));
      end
   endtask

   task automatic expect_idle(input string name);
      @(posedge clk);
      #1;
      check_val({name, "_busy"}, 32'(busy), 32'd0);
      check_val({name, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int dc0;

      checks       = 0;
      errors       = 0;
      done_count   = 0;
      reset        = 1'b0;
      start        = 1'b0;
      raw_mantissa = '0;
      raw_exponent = '0;
      raw_sign     = 1'b0;

      //            raw_m     raw_e  s     exp_m        exp_e  s     ovf   unf   lat
      vecs[0]  = '{19'h00080, 5'd14, 1'b0, 18'h20000,   5'd4,  1'b0, 1'b0, 1'b0, 12};
      vecs[1]  = '{19'b1101110110110000000, 5'd14, 1'b1,
                   18'b110111011011000000, 5'd15, 1'b1, 1'b0, 1'b0, 2};
      vecs[2]  = '{19'h40000, 5'd31, 1'b1, 18'h3FFFF,   5'd31, 1'b1, 1'b1, 1'b0, 2};
      vecs[3]  = '{19'h00000, 5'd9,  1'b1, 18'h00000,   5'd0,  1'b0, 1'b0, 1'b0, 2};
      vecs[4]  = '{19'h00080, 5'd3,  1'b1, 18'h00000,   5'd0,  1'b0, 1'b0, 1'b1, 5};
      vecs[5]  = '{19'h2ABCD, 5'd7,  1'b1, 18'h2ABCD,   5'd7,  1'b1, 1'b0, 1'b0, 2};
      vecs[6]  = '{19'h1FFFF, 5'd10, 1'b0, 18'h3FFFE,   5'd9,  1'b0, 1'b0, 1'b0, 3};
      vecs[7]  = '{19'h00001, 5'd20, 1'b1, 18'h20000,   5'd3,  1'b1, 1'b0, 1'b0, 19};
      vecs[8]  = '{19'h20001, 5'd0,  1'b0, 18'h20001,   5'd0,  1'b0, 1'b0, 1'b0, 2};
      vecs[9]  = '{19'h7FFFF, 5'd30, 1'b0, 18'h3FFFF,   5'd31, 1'b0, 1'b0, 1'b0, 2};
      vecs[10] = '{19'h10000, 5'd0,  1'b1, 18'h00000,   5'd0,  1'b0, 1'b0, 1'b1, 2};
      vecs[11] = '{19'h10000, 5'd1,  1'b1, 18'h20000,   5'd0,  1'b1, 1'b0, 1'b0, 3};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_c_mantissa", 32'(c_mantissa), 32'd0);
      check_val("rst_c_exponent", 32'(c_exponent), 32'd0);
      check_val("rst_c_sign",     32'(c_sign),     32'd0);
      check_val("rst_busy",       32'(busy),       32'd0);
      check_val("rst_done",       32'(done),       32'd0);
      check_val("rst_overflow",   32'(overflow),   32'd0);
      check_val("rst_underflow",  32'(underflow),  32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven vectors.
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(vecs[i], 1'b1);
         check_output(1);
         expect_idle("post_done");
      end

      // Start while busy is ignored, then a back-to-back start is accepted
      // in the first IDLE cycle.
      dc0 = done_count;
      apply_stimulus(vecs[0], 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      raw_mantissa = vecs[1].raw_m;
      raw_exponent = vecs[1].raw_e;
      raw_sign     = vecs[1].raw_s;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val("busy_during_shift", 32'(busy), 32'd1);
      check_output(5);
      raw_mantissa = vecs[1].raw_m;
      raw_exponent = vecs[1].raw_e;
      raw_sign     = vecs[1].raw_s;
      start        = 1'b1;
      sb_q.push_back(vecs[1]);
      @(posedge clk);
      #1;
      check_val("first_idle_busy", 32'(busy), 32'd0);
      check_val("first_idle_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val("b2b_accepted_busy", 32'(busy), 32'd1);
      check_output(1);
      expect_idle("b2b_post_done");
      check_val("handshake_done_pulses", 32'(done_count - dc0), 32'd2);

      // Asynchronous reset during SHIFT aborts without a done pulse.
      dc0 = done_count;
      apply_stimulus(vecs[0], 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b0;
      #1;
      check_val("abort_c_mantissa", 32'(c_mantissa), 32'd0);
      check_val("abort_c_exponent", 32'(c_exponent), 32'd0);
      check_val("abort_c_sign",     32'(c_sign),     32'd0);
      check_val("abort_busy",       32'(busy),       32'd0);
      check_val("abort_done",       32'(done),       32'd0);
      check_val("abort_overflow",   32'(overflow),   32'd0);
      check_val("abort_underflow",  32'(underflow),  32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("abort_no_done", 32'(done_count - dc0), 32'd0);
      apply_stimulus(vecs[1], 1'b1);
      check_output(1);
      expect_idle("after_reset_post_done");

      check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
